// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end for the 10-bit CPU: owns the PC, fetches one word
// per retire over a req/ack memory port and stops on halt or memory timeout.
//
// state   | meaning
// S_REQ   | request outstanding (imem_req registered, rises one cycle after entry from reset)
// S_ISSUE | instr valid, waiting for exec_done to pick the next PC
// S_HALT  | stopped by fetch_op=3, left only by reset
// S_FAULT | stopped by imem timeout, pc keeps the faulting address
module instr_fetch_unit #(
  parameter logic [9:0]  RESET_PC    = 10'd0,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic       clk,
  input  logic       reset,
  output logic       imem_req,
  output logic [9:0] imem_addr,
  input  logic       imem_ack,
  input  logic [9:0] imem_rdata,
  output logic [9:0] instr,
  output logic       instr_valid,
  input  logic       exec_done,
  input  logic [1:0] fetch_op,
  input  logic [9:0] jmp_addr,
  input  logic       branch_taken,
  input  logic [9:0] jr_target,
  output logic [9:0] pc,
  output logic [9:0] pc_plus1,
  output logic       halted,
  output logic       fault
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_ISSUE = 2'd1,
    S_HALT  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_SEQ  = 2'd0,
    OP_BR   = 2'd1,
    OP_JR   = 2'd2,
    OP_HALT = 2'd3
  } fetch_op_t;

  state_t           state_q, state_d;
  logic [9:0]       pc_q, pc_d;
  logic [9:0]       instr_q, instr_d;
  logic             valid_q, valid_d;
  logic             req_q, req_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [9:0] seq_pc;
  logic [9:0] br_pc;
  logic [9:0] next_pc;

  assign seq_pc = pc_q + 10'd1;
  assign br_pc  = branch_taken ? (pc_q + jmp_addr) : seq_pc;

  always_comb begin
    next_pc = seq_pc;
    case (fetch_op_t'(fetch_op))
      OP_BR:   next_pc = br_pc;
      OP_JR:   next_pc = jr_target;
      default: next_pc = seq_pc;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      instr_q <= 10'd0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_REQ: begin
        // The cycle right after reset has no request on the bus yet; ack and timeout wait for it.
        if (req_q) begin
          if (imem_ack) begin
            instr_d = imem_rdata;
            valid_d = 1'b1;
            cnt_d   = '0;
            state_d = S_ISSUE;
          end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = S_FAULT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_ISSUE: begin
        if (exec_done) begin
          valid_d = 1'b0;
          if (fetch_op_t'(fetch_op) == OP_HALT) begin
            state_d = S_HALT;
          end else begin
            pc_d    = next_pc;
            state_d = S_REQ;
          end
        end
      end
      S_HALT: begin
        valid_d = 1'b0;
      end
      S_FAULT: begin
        valid_d = 1'b0;
      end
    endcase

    req_d = (state_d == S_REQ);
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign pc_plus1    = pc_q + 10'd1;
  assign halted      = (state_q == S_HALT);
  assign fault       = (state_q == S_FAULT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a transaction-level PC model:
// each fetch/retire is one model step, with directed wrap, jr, halt, timeout and reset cases.
module tb_instr_fetch_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       imem_req;
  logic [9:0] imem_addr;
  logic       imem_ack;
  logic [9:0] imem_rdata;
  logic [9:0] instr;
  logic       instr_valid;
  logic       exec_done;
  logic [1:0] fetch_op;
  logic [9:0] jmp_addr;
  logic       branch_taken;
  logic [9:0] jr_target;
  logic [9:0] pc;
  logic [9:0] pc_plus1;
  logic       halted;
  logic       fault;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model: architectural PC and the last word handed to the control unit
  int m_pc    = 0;
  int m_instr = 0;

  instr_fetch_unit #(.RESET_PC(10'd0), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid),
    .exec_done(exec_done), .fetch_op(fetch_op),
    .jmp_addr(jmp_addr), .branch_taken(branch_taken), .jr_target(jr_target),
    .pc(pc), .pc_plus1(pc_plus1), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_fetch(input int word, input int delay);
    int n = 0;
    while (imem_req !== 1'b1 && n < 4) begin
      step();
      n++;
    end
    check_eq("req_up", int'(imem_req), 1);
    check_eq("fetch_addr", int'(imem_addr), m_pc);
    repeat (delay) step();
    imem_ack   = 1'b1;
    imem_rdata = 10'(word);
    step();
    imem_ack   = 1'b0;
    imem_rdata = 10'($urandom);
    m_instr    = word % 1024;
    check_eq("valid_set", int'(instr_valid), 1);
    check_eq("instr", int'(instr), m_instr);
    check_eq("req_drop", int'(imem_req), 0);
    check_eq("no_fault", int'(fault), 0);
  endtask

  task automatic do_retire(input int op, input int jmp, input bit tk, input int jr,
                           input int idle, input bit dbl);
    int  npc;
    bit  halt;
    repeat (idle) begin
      imem_ack   = 1'($urandom_range(0, 1));
      imem_rdata = 10'($urandom);
      step();
    end
    imem_ack = 1'b0;
    check_eq("valid_hold", int'(instr_valid), 1);
    check_eq("instr_hold", int'(instr), m_instr);
    check_eq("pc", int'(pc), m_pc);
    check_eq("pc_plus1", int'(pc_plus1), (m_pc + 1) % 1024);

    halt = (op == 3);
    case (op)
      1:       npc = tk ? (m_pc + jmp) % 1024 : (m_pc + 1) % 1024;
      2:       npc = jr % 1024;
      3:       npc = m_pc;
      default: npc = (m_pc + 1) % 1024;
    endcase

    fetch_op     = 2'(op);
    jmp_addr     = 10'(jmp);
    branch_taken = tk;
    jr_target    = 10'(jr);
    exec_done    = 1'b1;
    step();
    if (dbl) step();
    exec_done    = 1'b0;
    fetch_op     = 2'($urandom);
    jmp_addr     = 10'($urandom);
    branch_taken = 1'($urandom);
    jr_target    = 10'($urandom);
    m_pc         = npc;

    check_eq("retire_valid_clr", int'(instr_valid), 0);
    check_eq("retire_pc", int'(pc), m_pc);
    if (halt) begin
      check_eq("halted", int'(halted), 1);
      check_eq("halt_req", int'(imem_req), 0);
    end else begin
      check_eq("refetch_req", int'(imem_req), 1);
      check_eq("refetch_addr", int'(imem_addr), m_pc);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset   = 1'b0;
    m_pc    = 0;
    m_instr = 0;
  endtask

  initial begin
    int t;
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0; exec_done = 1'b0;
    fetch_op = '0; jmp_addr = '0; branch_taken = 1'b0; jr_target = '0;
    apply_reset();
    check_eq("rst_req", int'(imem_req), 0);
    check_eq("rst_pc", int'(pc), 0);
    check_eq("rst_valid", int'(instr_valid), 0);
    check_eq("rst_instr", int'(instr), 0);
    check_eq("rst_halted", int'(halted), 0);
    check_eq("rst_fault", int'(fault), 0);

    // sequential fetch, then backward branch from 0x002 wrapping to 0x3FE
    do_fetch('h100, 0); do_retire(0, 0, 0, 0, 0, 0);
    do_fetch('h101, 0); do_retire(0, 0, 0, 0, 1, 0);
    do_fetch('h102, 0); do_retire(1, 'h3FC, 1, 0, 0, 0);
    check_eq("branch_back", int'(imem_addr), 'h3FE);
    do_fetch('h0AA, 1); do_retire(0, 0, 0, 0, 0, 0);
    do_fetch('h0AB, 0); do_retire(0, 0, 0, 0, 2, 0);
    check_eq("wrap_zero", int'(imem_addr), 0);
    do_fetch('h155, 0); do_retire(1, 'h200, 0, 0, 0, 0);
    check_eq("not_taken", int'(imem_addr), 1);
    do_fetch('h2AA, 2); do_retire(2, 0, 1, 'h2A5, 0, 0);
    check_eq("jr", int'(imem_addr), 'h2A5);
    do_fetch('h300, 0); do_retire(2, 0, 0, 'h010, 0, 1);
    do_fetch('h301, 0);
    check_eq("jal_link", int'(pc_plus1), 'h011);
    do_retire(1, 'h008, 1, 0, 1, 0);
    check_eq("jal_target", int'(pc), 'h018);

    for (int i = 0; i < 60; i++) begin
      do_fetch(int'($urandom_range(0, 1023)), int'($urandom_range(0, 13)));
      do_retire(int'($urandom_range(0, 2)), int'($urandom_range(0, 1023)),
                1'($urandom), int'($urandom_range(0, 1023)),
                int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
    end

    // ack on the 16th request cycle still completes the fetch
    do_fetch('h3C3, 15);
    do_retire(0, 0, 0, 0, 0, 0);

    // async reset between edges, three cycles into a request
    repeat (3) step();
    #2 reset = 1'b1;
    #1;
    check_eq("arst_req", int'(imem_req), 0);
    check_eq("arst_valid", int'(instr_valid), 0);
    check_eq("arst_pc", int'(pc), 0);
    @(negedge clk);
    reset = 1'b0;
    m_pc = 0; m_instr = 0;
    do_fetch('h0F0, 0);
    t = int'($urandom_range(1, 1023));
    do_retire(2, 0, 0, t, 0, 0);

    // withheld ack: fault after 16 request cycles
    repeat (15) step();
    check_eq("pre_timeout_fault", int'(fault), 0);
    check_eq("pre_timeout_req", int'(imem_req), 1);
    step();
    check_eq("timeout_fault", int'(fault), 1);
    check_eq("timeout_req", int'(imem_req), 0);
    check_eq("timeout_pc", int'(pc), t);
    for (int i = 0; i < 5; i++) begin
      imem_ack = 1'($urandom); exec_done = 1'($urandom);
      step();
      check_eq("fault_sticky", int'(fault), 1);
      check_eq("fault_req", int'(imem_req), 0);
      check_eq("fault_pc", int'(pc), t);
    end
    imem_ack = 1'b0; exec_done = 1'b0;

    // halt: stays parked through stray acks and retires
    apply_reset();
    do_fetch('h1FF, 0); do_retire(0, 0, 0, 0, 0, 0);
    do_fetch('h3FF, 0); do_retire(3, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      imem_ack = 1'($urandom); exec_done = 1'($urandom);
      imem_rdata = 10'($urandom); fetch_op = 2'($urandom);
      step();
      check_eq("halt_req_low", int'(imem_req), 0);
      check_eq("halt_pc", int'(pc), m_pc);
      check_eq("halt_state", int'(halted), 1);
      check_eq("halt_instr", int'(instr), m_instr);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
